// File: rtl/rs_chien_search_if.sv
// Chien search request/result bundle: locator polynomial in, root positions out.
// Request is a single start pulse; results are registered by the search block.
// No backpressure: roots stream out one position per clock while busy.
interface rs_chien_search_if #(
  parameter int T = 8
);
  logic                   start;
  logic [8*(T+1)-1:0]     lambda;
  logic [7:0]             lambda_deg;
  logic                   busy;
  logic                   err_valid;
  logic [7:0]             err_idx;
  logic [7:0]             err_cnt;
  logic                   done;
  logic                   fail;

  modport master (
    output start, lambda, lambda_deg,
    input  busy, err_valid, err_idx, err_cnt, done, fail
  );

  modport slave (
    input  start, lambda, lambda_deg,
    output busy, err_valid, err_idx, err_cnt, done, fail
  );
endinterface

// File: rtl/rs_chien_search.sv
// Sequential GF(256) Chien search: flags every codeword position p where lambda(alpha^-p) == 0.
// Latency: N+1 cycles from accepted start to done; one position evaluated per clock.
// No backpressure: start is ignored while busy, results are emitted unconditionally.
module rs_chien_search #(
  parameter int N = 255,
  parameter int T = 8
) (
  input logic             clk,
  input logic             rst,
  rs_chien_search_if.slave bus
);

  // Exponent offset that moves the first evaluation point to alpha^-(N-1).
  localparam int SHIFT = (256 - N) % 255;

  typedef enum logic {
    IDLE   = 1'b0,
    SEARCH = 1'b1
  } state_t;

  // Polynomial product reduced modulo x^8+x^4+x^3+x^2+1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    acc = 8'h00;
    x   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
    end
    return acc;
  endfunction

  // alpha^e, only used to build elaboration-time constants.
  function automatic logic [7:0] gf_pow(input int e);
    logic [7:0] x;
    x = 8'h01;
    for (int i = 0; i < e; i++) begin
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
    end
    return x;
  endfunction

  state_t     state;
  logic [7:0] r     [0:T];
  logic [7:0] load  [0:T];
  logic [7:0] step  [0:T];
  logic [7:0] pos;
  logic [7:0] deg;
  logic [7:0] cnt;
  logic [7:0] idx;
  logic       busy;
  logic       err_valid;
  logic       done;
  logic       fail;
  logic [7:0] sum;
  logic       hit;
  logic [7:0] cnt_next;

  // Per-term constant multipliers: load scaling and per-position step alpha^j.
  for (genvar j = 0; j <= T; j++) begin : g_term
    localparam logic [7:0] INIT_C = gf_pow((j * SHIFT) % 255);
    localparam logic [7:0] STEP_C = gf_pow(j % 255);
    assign load[j] = gf_mul(bus.lambda[8*j +: 8], INIT_C);
    assign step[j] = gf_mul(r[j], STEP_C);
  end

  // Evaluate lambda at the current point: sum of all running terms.
  always_comb begin
    sum = 8'h00;
    for (int j = 0; j <= T; j++) begin
      sum = sum ^ r[j];
    end
  end

  assign hit      = (sum == 8'h00);
  assign cnt_next = cnt + {7'd0, hit};

  // Search sequencer: load on start, step one position per clock, report at the end.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pos       <= 8'h00;
      deg       <= 8'h00;
      cnt       <= 8'h00;
      idx       <= 8'h00;
      busy      <= 1'b0;
      err_valid <= 1'b0;
      done      <= 1'b0;
      fail      <= 1'b0;
      for (int j = 0; j <= T; j++) begin
        r[j] <= 8'h00;
      end
    end else begin
      err_valid <= 1'b0;
      done      <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            r     <= load;
            pos   <= 8'(N - 1);
            cnt   <= 8'h00;
            deg   <= bus.lambda_deg;
            fail  <= 1'b0;
            busy  <= 1'b1;
            state <= SEARCH;
          end
        end
        SEARCH: begin
          err_valid <= hit;
          if (hit) begin
            idx <= pos;
            cnt <= cnt_next;
          end
          r   <= step;
          pos <= pos - 8'd1;
          if (pos == 8'h00) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            // A correctable pattern has exactly deg roots and deg within capacity.
            fail  <= (cnt_next != deg) || (deg > 8'(T));
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy      = busy;
  assign bus.err_valid = err_valid;
  assign bus.err_idx   = idx;
  assign bus.err_cnt   = cnt;
  assign bus.done      = done;
  assign bus.fail      = fail;

endmodule
